// File: rtl/fc_result_pkg.sv
// fc_result_pkg: shared FSM state type, default score width and decision constants
// for frame_result_tx.
package fc_result_pkg;
    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;
    localparam int SCORE_W_DEF = 16;
    localparam logic DEC_AWAKE = 1'b1;
    localparam logic DEC_SLEEP = 1'b0;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/maj3_debounce.sv
// maj3_debounce: majority-of-3 filter over the current raw decision and the two
// previous accepted ones; history starts as all-awake.
module maj3_debounce
    import fc_result_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_raw,
    output logic o_dec
);
    logic [1:0] r_hist;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hist <= {DEC_AWAKE, DEC_AWAKE};
        else if (i_en) r_hist <= {r_hist[0], i_raw};
    end
    assign o_dec = maj3(i_raw, r_hist[0], r_hist[1]);
endmodule

// File: rtl/frame_result_tx.sv
// frame_result_tx: turns one FC score pair per frame into a fixed-width valid_out
// pulse plus gap; FRAME_RESULT_DEBOUNCE_EN adds a majority-of-3 decision filter.
module frame_result_tx
    import fc_result_pkg::*;
#(
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] score_awake,
    input  logic [SCORE_W-1:0] score_sleep,
    output logic               valid_out,
    output logic               data_out,
    output logic [15:0]        frame_cnt
);
    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_data;
    logic [15:0]      r_frame_cnt;
    logic             w_accept;
    logic             w_raw;
    logic             w_dec;

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid && in_ready;
    assign w_raw     = ($signed(score_awake) >= $signed(score_sleep)) ? DEC_AWAKE : DEC_SLEEP;
    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign frame_cnt = r_frame_cnt;

`ifdef FRAME_RESULT_DEBOUNCE_EN
    maj3_debounce u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_accept),
        .i_raw (w_raw),
        .o_dec (w_dec)
    );
`else
    assign w_dec = w_raw;
`endif

    // One down-counter times both the pulse and the gap phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_data      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state     <= EMIT;
                    r_valid     <= 1'b1;
                    r_data      <= w_dec;
                    r_cnt       <= CNT_W'(PULSE_LEN - 1);
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
                EMIT: if (r_cnt == '0) begin
                    r_state <= GAP;
                    r_valid <= 1'b0;
                    r_cnt   <= CNT_W'(GAP_LEN - 1);
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                GAP: if (r_cnt == '0) r_state <= IDLE;
                     else r_cnt <= r_cnt - CNT_W'(1);
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_result_tx.sv
// tb_frame_result_tx: directed self-checking bench for frame_result_tx (default
// parameters); expectations follow FRAME_RESULT_DEBOUNCE_EN when it is defined.
module tb_frame_result_tx;
`ifdef FRAME_RESULT_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] score_awake = '0;
    logic [15:0] score_sleep = '0;
    logic        valid_out;
    logic        data_out;
    logic [15:0] frame_cnt;
    int          n_chk = 0;
    int          n_pass = 0;

    frame_result_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .score_awake (score_awake),
        .score_sleep (score_sleep),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full frame from IDLE; in_valid stays high with opposite-decision scores
    // through EMIT/GAP to exercise back-pressure.
    task automatic frame(input logic [15:0] aw, input logic [15:0] sl, input logic exp);
        score_awake = aw;
        score_sleep = sl;
        in_valid = 1'b1;
        @(negedge clk);
        check("emit1_ready", 32'(in_ready), 0);
        check("emit1_valid", 32'(valid_out), 1);
        check("emit1_data", 32'(data_out), 32'(exp));
        score_awake = exp ? 16'h8000 : 16'h7fff;
        score_sleep = exp ? 16'h7fff : 16'h8000;
        @(negedge clk);
        check("emit2_valid", 32'(valid_out), 1);
        check("emit2_data", 32'(data_out), 32'(exp));
        @(negedge clk);
        check("gap_valid", 32'(valid_out), 0);
        check("gap_ready", 32'(in_ready), 0);
        check("gap_data", 32'(data_out), 32'(exp));
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 1);
        check("idle_valid", 32'(valid_out), 0);
        check("idle_data", 32'(data_out), 32'(exp));
    endtask

    initial begin
        int   rises [8];
        int   nr;
        logic prev;
        logic [3:0] exp_seq;
        logic [3:0] raw_seq;
        @(negedge clk);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
        check("rst_ready", 32'(in_ready), 1);
        rst_n = 1'b1;

        frame(16'd5, 16'hfffd, 1'b1);
        check("cnt_one", 32'(frame_cnt), 1);

        do_reset();
        frame(16'hff9c, 16'hff9c, 1'b1);
        frame(16'h8000, 16'h0000, DEB ? 1'b1 : 1'b0);
        check("cnt_two", 32'(frame_cnt), 2);

        do_reset();
        score_awake = 16'd1;
        score_sleep = 16'd2;
        in_valid = 1'b1;
        nr = 0;
        prev = valid_out;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (valid_out && !prev && nr < 8) begin
                rises[nr] = k;
                nr++;
            end
            prev = valid_out;
            if (k == 16) in_valid = 1'b0;
        end
        check("rise_count", 32'(nr), 4);
        if (nr >= 4)
            for (int i = 1; i < 4; i++) check("rise_period", 32'(rises[i] - rises[i-1]), 4);
        check("cnt_four", 32'(frame_cnt), 4);
        repeat (4) @(negedge clk);

        do_reset();
        score_awake = 16'd5;
        score_sleep = 16'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid_out), 0);
        check("arst_cnt", 32'(frame_cnt), 0);
        check("arst_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_resume", 32'(valid_out), 0);
        end
        frame(16'd5, 16'd0, 1'b1);
        check("cnt_after_arst", 32'(frame_cnt), 1);

        do_reset();
        raw_seq = 4'b0100;
        exp_seq = DEB ? 4'b0001 : 4'b0100;
        for (int i = 0; i < 4; i++)
            frame(raw_seq[i] ? 16'd1 : 16'd0, raw_seq[i] ? 16'd0 : 16'd1, exp_seq[i]);

        @(negedge clk);
        force dut.r_frame_cnt = 16'hfffe;
        @(negedge clk);
        release dut.r_frame_cnt;
        @(negedge clk);
        check("preload", 32'(frame_cnt), 32'hfffe);
        frame(16'd3, 16'd3, 1'b1);
        check("cnt_ffff", 32'(frame_cnt), 32'hffff);
        frame(16'd3, 16'd3, 1'b1);
        check("cnt_wrap", 32'(frame_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
